ysyx_22040750_fetch_ctrl: RTL and testbench
===========================================

# ysyx_22040750_fetch_ctrl

Fetch-PC controller and redirect arbiter for the pipelined core. It owns the architectural fetch PC and issues it to IF over a valid/ready handshake. It arbitrates same-cycle redirect requests from the trap/CSR path (WB), resolved jalr/branch (EX) and jal (ID), and drives the matching pipeline flushes. It also tracks outstanding fetches so that wrong-path responses returning after a redirect are discarded.

## Interface
- RST_PC, 32'h8000_0000, PC issued first after reset
- OUTST, 2, maximum fetches in flight (1..3)
- I_clk  in  1  clock
- I_rst  in  1  reset, synchronous, active-high
- I_intr_valid  in  1  trap/mret redirect request (WB)
- I_intr_pc  in  32  trap/mret target
- I_ex_valid  in  1  jalr / taken-branch redirect request (EX)
- I_ex_pc  in  32  EX target
- I_id_valid  in  1  jal redirect request (ID)
- I_id_pc  in  32  ID target
- O_fetch_valid  out  1  O_fetch_pc valid for IF
- I_fetch_ready  in  1  IF accepts PC
- O_fetch_pc  out  32  PC to fetch
- I_resp_valid  in  1  IF returns one instruction (in issue order)
- O_resp_discard  out  1  current response is wrong-path; IF/ID must not load it
- O_flush_id  out  1  clear IF/ID register
- O_flush_ex  out  1  clear ID/EX register

## Operation
- State machine: BOOT (entered by reset; O_fetch_valid=0) -> RUN unconditionally after one cycle. Only reset returns to BOOT.
- Handshake: hs = O_fetch_valid & I_fetch_ready.
- O_fetch_valid = (state==RUN) & (outst < OUTST). It is registered-state-derived and does not depend on I_fetch_ready.
- Redirect select uses fixed priority intr > ex > id, with redir = any valid. Lower-priority requests in the same cycle are dropped.
- Flushes are combinational and forced 0 during reset:
  - intr or ex winning: O_flush_id=1, O_flush_ex=1.
  - id winning: O_flush_id=1 only.
  - A lower-priority request never adds flushes.
- PC register pc_q:
  - on redir: pc_q <= {target[31:1],1'b0}.
  - else on hs: pc_q <= pc_q + 4, modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
  - else hold.
- Redirect has precedence over hs in the same cycle. The handshaken PC counts as in flight and becomes stale.
- O_fetch_pc = pc_q. It may change while O_fetch_valid=1 without a handshake, but only due to a redirect. IF samples the PC only on hs.
- Outstanding counter (2 bits): outst_next = outst + hs - I_resp_valid. I_resp_valid with outst==0 is a protocol error and the counter saturates at 0.
- Stale counter:
  - on redir: stale <= outst_next.
  - else on I_resp_valid with stale!=0: stale <= stale - 1.
  - else hold.
- O_resp_discard = I_resp_valid & ((stale != 0) | redir).
- A redirect in the same cycle as a response discards that response, since IF/ID is being flushed.
- Back-to-back redirects on consecutive cycles: each one reloads pc_q and stale from the current outst_next. The last redirect wins.

## Timing
- Reset values: state=BOOT, pc_q=RST_PC, outst=0, stale=0.
- Outputs during reset: O_fetch_valid=0, O_fetch_pc=RST_PC, O_resp_discard=0, flushes=0.
- First cycle after I_rst falls: O_fetch_valid=0. Next cycle: O_fetch_valid=1, O_fetch_pc=RST_PC.
- Redirect latency: request in cycle N -> O_fetch_pc=target in N+1. Flushes are asserted in N only (one-cycle pulse per request cycle).
- Sequential throughput: one PC per cycle while I_fetch_ready=1 and outst<OUTST.
- outst==OUTST with a response in the same cycle: valid stays 0 this cycle and returns in the next cycle.
- Reset mid-operation clears outst and stale. Responses from before the reset are the responsibility of IF reset.

## Test plan
- Boot: I_rst high 3 cycles, ready=1, resp returned 1 cycle after hs -> valid 0 for one cycle, then PCs 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles.
- Priority: intr 0x8000_1000, ex 0x8000_2000, id 0x8000_3000 in the same cycle -> O_flush_id=O_flush_ex=1 that cycle; O_fetch_pc=0x8000_1000 next cycle. Id alone to 0x8000_3000 -> only O_flush_id=1.
- Stale drop: two hs with no responses, so outst=2 and valid=0; ex redirect to 0x8000_0100 -> next two responses have discard=1, the third has discard=0, and the first PC after the redirect is 0x8000_0100.
- Same-cycle redirect+hs+resp: outst=1, ex redirect with hs and resp in one cycle -> that resp has discard=1; stale=1; the following resp has discard=1.
- Wrap/alignment: ex target 0xFFFF_FFFD -> O_fetch_pc=0xFFFF_FFFC; after hs -> 0x0000_0000.
- Reset mid-flight: outst=2, stale=1, then I_rst for 1 cycle -> all counters 0, O_fetch_valid=0, then RST_PC reissued two cycles later.

Source files
------------

// File: rtl/ysyx_22040750_fetch_ctrl.sv
// Fetch-PC controller: owns the fetch PC, arbitrates redirects,
// drives pipeline flushes and discards wrong-path fetch responses.
module ysyx_22040750_fetch_ctrl #(
    parameter logic [31:0] RST_PC = 32'h8000_0000,
    parameter int          OUTST  = 2
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_intr_valid,
    input  logic [31:0] I_intr_pc,
    input  logic        I_ex_valid,
    input  logic [31:0] I_ex_pc,
    input  logic        I_id_valid,
    input  logic [31:0] I_id_pc,
    output logic        O_fetch_valid,
    input  logic        I_fetch_ready,
    output logic [31:0] O_fetch_pc,
    input  logic        I_resp_valid,
    output logic        O_resp_discard,
    output logic        O_flush_id,
    output logic        O_flush_ex
);

    localparam logic [1:0] CAP = 2'(OUTST);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [1:0]  outst;
    logic [1:0]  stale;
    logic [1:0]  outst_next;
    logic        hs;
    logic        redir;
    logic        redir_full;
    logic [31:0] target;

    assign O_fetch_valid = ~I_rst & (state == RUN) & (outst < CAP);
    assign O_fetch_pc    = pc_q;
    assign hs            = O_fetch_valid & I_fetch_ready;

    // Fixed-priority redirect select: trap/mret, then EX, then ID.
    always_comb begin
        redir      = 1'b0;
        redir_full = 1'b0;
        target     = pc_q;
        if (I_intr_valid) begin
            redir      = 1'b1;
            redir_full = 1'b1;
            target     = I_intr_pc;
        end else if (I_ex_valid) begin
            redir      = 1'b1;
            redir_full = 1'b1;
            target     = I_ex_pc;
        end else if (I_id_valid) begin
            redir      = 1'b1;
            target     = I_id_pc;
        end
    end

    assign O_flush_id     = ~I_rst & redir;
    assign O_flush_ex     = ~I_rst & redir_full;
    assign O_resp_discard = ~I_rst & I_resp_valid
                          & ((stale != 2'd0) | redir);

    // Next in-flight count; a response with nothing in flight is ignored.
    always_comb begin
        outst_next = outst;
        if (hs && !I_resp_valid) begin
            outst_next = outst + 2'd1;
        end else if (!hs && I_resp_valid && outst != 2'd0) begin
            outst_next = outst - 2'd1;
        end
    end

    // Boot FSM plus PC, in-flight and stale bookkeeping.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= BOOT;
            pc_q  <= RST_PC;
            outst <= 2'd0;
            stale <= 2'd0;
        end else begin
            state <= RUN;
            outst <= outst_next;
            if (redir) begin
                pc_q  <= {target[31:1], 1'b0};
                stale <= outst_next;
            end else begin
                if (hs) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (I_resp_valid && stale != 2'd0) begin
                    stale <= stale - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040750_fetch_ctrl.sv
// Self-checking bench for ysyx_22040750_fetch_ctrl: directed
// scenarios followed by random traffic against a queue-based model.
module tb_ysyx_22040750_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          OUTST  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        intr_valid, ex_valid, id_valid;
    logic [31:0] intr_pc, ex_pc, id_pc;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_pc;
    logic        resp_valid, resp_discard;
    logic        flush_id, flush_ex;

    int tests  = 0;
    int failed = 0;

    // Model: one entry per fetch in flight, flag = wrong-path.
    bit          mq[$];
    logic [31:0] m_pc;
    bit          m_known = 0;
    bit          m_run   = 0;

    always #5 clk = ~clk;

    ysyx_22040750_fetch_ctrl #(.RST_PC(RST_PC), .OUTST(OUTST)) dut (
        .I_clk(clk), .I_rst(rst),
        .I_intr_valid(intr_valid), .I_intr_pc(intr_pc),
        .I_ex_valid(ex_valid), .I_ex_pc(ex_pc),
        .I_id_valid(id_valid), .I_id_pc(id_pc),
        .O_fetch_valid(fetch_valid), .I_fetch_ready(fetch_ready),
        .O_fetch_pc(fetch_pc),
        .I_resp_valid(resp_valid), .O_resp_discard(resp_discard),
        .O_flush_id(flush_id), .O_flush_ex(flush_ex)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit rdy, input bit rsp,
                         input bit iv, input logic [31:0] ip,
                         input bit ev, input logic [31:0] ep,
                         input bit dv, input logic [31:0] dp);
        rst = r; fetch_ready = rdy; resp_valid = rsp;
        intr_valid = iv; intr_pc = ip;
        ex_valid = ev; ex_pc = ep;
        id_valid = dv; id_pc = dp;
    endtask

    // Check outputs mid-cycle against the model, then advance it.
    task automatic cycle();
        bit          e_valid, e_hs, e_redir, e_full, e_disc;
        logic [31:0] tgt;
        #4;
        if (rst) begin
            chk("rst_valid", 32'(fetch_valid), 32'd0);
            chk("rst_disc", 32'(resp_discard), 32'd0);
            chk("rst_flush", {30'd0, flush_id, flush_ex}, 32'd0);
            if (m_known) chk("rst_pc", fetch_pc, m_pc);
            m_pc = RST_PC; m_known = 1; m_run = 0;
            mq.delete();
        end else if (m_known) begin
            e_valid = m_run && (mq.size() < OUTST);
            e_hs    = e_valid && fetch_ready;
            e_redir = intr_valid || ex_valid || id_valid;
            e_full  = intr_valid || ex_valid;
            tgt     = intr_valid ? intr_pc : ex_valid ? ex_pc : id_pc;
            e_disc  = resp_valid && (e_redir || (mq.size() > 0 && mq[0]));
            chk("valid", 32'(fetch_valid), 32'(e_valid));
            chk("pc", fetch_pc, m_pc);
            chk("discard", 32'(resp_discard), 32'(e_disc));
            chk("flush_id", 32'(flush_id), 32'(e_redir));
            chk("flush_ex", 32'(flush_ex), 32'(e_full));
            if (resp_valid && mq.size() > 0) void'(mq.pop_front());
            if (e_hs) mq.push_back(1'b0);
            if (e_redir) begin
                foreach (mq[i]) mq[i] = 1'b1;
                m_pc = tgt & 32'hFFFF_FFFE;
            end else if (e_hs) begin
                m_pc = m_pc + 32'd4;
            end
            m_run = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        m_known = 1; m_pc = RST_PC;
        // Boot
        repeat (3) cycle();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("boot_v0", 32'(fetch_valid), 32'd0);
        cycle();
        chk("boot_v1", 32'(fetch_valid), 32'd1);
        chk("boot_pc0", fetch_pc, 32'h8000_0000);
        cycle();
        chk("boot_pc1", fetch_pc, 32'h8000_0004);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("boot_pc2", fetch_pc, 32'h8000_0008);
        cycle();
        // Priority
        drive(0, 0, 1, 1, 32'h8000_1000, 1, 32'h8000_2000,
              1, 32'h8000_3000);
        #1;
        chk("pri_fid", 32'(flush_id), 32'd1);
        chk("pri_fex", 32'(flush_ex), 32'd1);
        cycle();
        chk("pri_pc", fetch_pc, 32'h8000_1000);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_3000);
        #1;
        chk("id_fid", 32'(flush_id), 32'd1);
        chk("id_fex", 32'(flush_ex), 32'd0);
        cycle();
        chk("id_pc", fetch_pc, 32'h8000_3000);
        // Stale drop
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("full_v", 32'(fetch_valid), 32'd0);
        drive(0, 1, 0, 0, 0, 1, 32'h8000_0100, 0, 0);
        cycle();
        chk("stale_pc", fetch_pc, 32'h8000_0100);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("stale_d1", 32'(resp_discard), 32'd1);
        cycle();
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("stale_d2", 32'(resp_discard), 32'd1);
        cycle();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("stale_d3", 32'(resp_discard), 32'd0);
        cycle();
        // Redirect + hs + resp in one cycle
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 1, 1, 0, 0, 1, 32'h8000_0200, 0, 0);
        #1;
        chk("same_d1", 32'(resp_discard), 32'd1);
        cycle();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk("same_d2", 32'(resp_discard), 32'd1);
        cycle();
        // Wrap and alignment
        drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFD, 0, 0);
        cycle();
        chk("wrap_al", fetch_pc, 32'hFFFF_FFFC);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("wrap_pc", fetch_pc, 32'h0000_0000);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        // Reset mid-flight (outst=2, stale=1)
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        drive(0, 0, 0, 0, 0, 1, 32'h8000_0400, 0, 0);
        cycle();
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("mr_v0", 32'(fetch_valid), 32'd0);
        cycle();
        chk("mr_v1", 32'(fetch_valid), 32'd1);
        chk("mr_pc", fetch_pc, RST_PC);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        // Random traffic
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(99) == 0),
                  ($urandom_range(3) != 0),
                  (mq.size() > 0) && ($urandom_range(1) == 1),
                  ($urandom_range(19) == 0), $urandom(),
                  ($urandom_range(9) == 0), $urandom(),
                  ($urandom_range(9) == 0), $urandom());
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
